// File: rtl/conv_pkg.sv
// Constants and types shared by the convolution filter, the border framer
// and the frame-buffer writer.
package conv_pkg;
  localparam int W      = 30;
  localparam int WIDTH  = 320;
  localparam int HEIGHT = 240;
  localparam int BORDER = 2;

  typedef logic [W-1:0] pixel_t;

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } framer_state_t;
endpackage

// File: rtl/conv_border_framer_raster_counter.sv
// Column/row raster counter with synchronous clear and advance; wraps at the
// end of each line and at the end of the frame.
module raster_counter
  import conv_pkg::*;
#(
  parameter int WIDTH  = conv_pkg::WIDTH,
  parameter int HEIGHT = conv_pkg::HEIGHT
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      i_clear,
  input  logic                      i_advance,
  output logic [$clog2(WIDTH)-1:0]  o_col,
  output logic [$clog2(HEIGHT)-1:0] o_row,
  output logic                      o_last_col,
  output logic                      o_last_pixel
);
  localparam int CW = $clog2(WIDTH);
  localparam int RW = $clog2(HEIGHT);
  localparam logic [CW-1:0] COL_MAX = CW'(WIDTH - 1);
  localparam logic [RW-1:0] ROW_MAX = RW'(HEIGHT - 1);

  logic [CW-1:0] r_col;
  logic [RW-1:0] r_row;
  logic          w_last_row;

  assign w_last_row   = (r_row == ROW_MAX);
  assign o_last_col   = (r_col == COL_MAX);
  assign o_last_pixel = o_last_col & w_last_row;
  assign o_col        = r_col;
  assign o_row        = r_row;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_col <= '0;
      r_row <= '0;
    end else if (i_clear) begin
      r_col <= '0;
      r_row <= '0;
    end else if (i_advance) begin
      if (o_last_col) begin
        r_col <= '0;
        r_row <= w_last_row ? '0 : r_row + 1'b1;
      end else begin
        r_col <= r_col + 1'b1;
      end
    end
  end
endmodule

// File: rtl/conv_border_framer.sv
// Frames the 5x5 filter output stream: raster coordinates, border fill,
// SOF/EOL tagging, frame_start re-sync and dropping of out-of-frame beats.
module conv_border_framer
  import conv_pkg::*;
#(
  parameter int             W            = conv_pkg::W,
  parameter int             WIDTH        = conv_pkg::WIDTH,
  parameter int             HEIGHT       = conv_pkg::HEIGHT,
  parameter int             BORDER       = conv_pkg::BORDER,
  parameter logic [W-1:0]   BORDER_COLOR = '0
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         frame_start,
  input  logic [W-1:0] x_data,
  input  logic         x_valid,
  output logic         x_ready,
  output logic [W-1:0] y_data,
  output logic         y_valid,
  input  logic         y_ready,
  output logic         y_sof,
  output logic         y_eol,
  output logic         frame_done,
  output logic [7:0]   resync_count,
  output logic [15:0]  drop_count
);
  localparam int CW = $clog2(WIDTH);
  localparam int RW = $clog2(HEIGHT);
  localparam logic [CW-1:0] COL_LO = CW'(BORDER);
  localparam logic [CW-1:0] COL_HI = CW'(WIDTH - BORDER);
  localparam logic [RW-1:0] ROW_LO = RW'(BORDER);
  localparam logic [RW-1:0] ROW_HI = RW'(HEIGHT - BORDER);

  framer_state_t r_state;
  logic [W-1:0]  r_y_data;
  logic          r_y_valid, r_y_sof, r_y_eol, r_y_last;
  logic [7:0]    r_resync;
  logic [15:0]   r_drop;

  logic [CW-1:0] w_col;
  logic [RW-1:0] w_row;
  logic          w_last_col, w_last_pixel;
  logic          w_accept, w_clear, w_advance, w_border;

  assign x_ready  = ~r_y_valid | y_ready;
  assign w_accept = x_valid & x_ready;
  assign w_border = (w_col < COL_LO) | (w_col >= COL_HI) |
                    (w_row < ROW_LO) | (w_row >= ROW_HI);

  // The beat at the current coordinates is emitted before any clear takes effect.
  always_comb begin
    w_clear   = 1'b0;
    w_advance = 1'b0;
    if (r_state == IDLE) begin
      w_clear = frame_start;
    end else if (w_accept & w_last_pixel) begin
      w_clear = 1'b1;
    end else if (frame_start) begin
      w_clear = 1'b1;
    end else if (w_accept) begin
      w_advance = 1'b1;
    end
  end

  raster_counter #(
    .WIDTH (WIDTH),
    .HEIGHT(HEIGHT)
  ) u_raster (
    .clk         (clk),
    .reset       (reset),
    .i_clear     (w_clear),
    .i_advance   (w_advance),
    .o_col       (w_col),
    .o_row       (w_row),
    .o_last_col  (w_last_col),
    .o_last_pixel(w_last_pixel)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state   <= IDLE;
      r_y_data  <= '0;
      r_y_valid <= 1'b0;
      r_y_sof   <= 1'b0;
      r_y_eol   <= 1'b0;
      r_y_last  <= 1'b0;
      r_resync  <= '0;
      r_drop    <= '0;
    end else begin
      if (w_accept && r_state == RUN) begin
        r_y_valid <= 1'b1;
        r_y_data  <= w_border ? BORDER_COLOR : x_data;
        r_y_sof   <= (w_col == '0) & (w_row == '0);
        r_y_eol   <= w_last_col;
        r_y_last  <= w_last_pixel;
      end else if (y_ready) begin
        r_y_valid <= 1'b0;
      end

      if (r_state == IDLE) begin
        if (w_accept && r_drop != 16'hFFFF) r_drop <= r_drop + 1'b1;
        if (frame_start) r_state <= RUN;
      end else begin
        // A frame_start on the final pixel simply begins the next frame.
        if (w_accept & w_last_pixel) begin
          r_state <= frame_start ? RUN : IDLE;
        end else if (frame_start && r_resync != 8'hFF) begin
          r_resync <= r_resync + 1'b1;
        end
      end
    end
  end

  assign y_data       = r_y_data;
  assign y_valid      = r_y_valid;
  assign y_sof        = r_y_sof;
  assign y_eol        = r_y_eol;
  assign frame_done   = r_y_valid & y_ready & r_y_last;
  assign resync_count = r_resync;
  assign drop_count   = r_drop;
endmodule

// File: tb/tb_conv_border_framer.sv
// Bench for conv_border_framer on a reduced 16x12 raster: reference model and
// scoreboard on the stream, table checks on a captured coordinate-coded frame.
module tb_conv_border_framer;
  localparam int WB   = 16;
  localparam int HB   = 12;
  localparam int NPIX = WB * HB;
  localparam logic [29:0] CONST_PIX = 30'h3FFF_FFFF;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        frame_start = 1'b0;
  logic [29:0] x_data = '0;
  logic        x_valid = 1'b0;
  logic        x_ready;
  logic [29:0] y_data;
  logic        y_valid;
  logic        y_ready = 1'b1;
  logic        y_sof, y_eol, frame_done;
  logic [7:0]  resync_count;
  logic [15:0] drop_count;

  conv_border_framer #(
    .W(30), .WIDTH(WB), .HEIGHT(HB), .BORDER(2), .BORDER_COLOR(30'h0)
  ) dut (
    .clk(clk), .reset(reset), .frame_start(frame_start),
    .x_data(x_data), .x_valid(x_valid), .x_ready(x_ready),
    .y_data(y_data), .y_valid(y_valid), .y_ready(y_ready),
    .y_sof(y_sof), .y_eol(y_eol), .frame_done(frame_done),
    .resync_count(resync_count), .drop_count(drop_count)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [29:0] d;
    logic        sof;
    logic        eol;
    logic        last;
  } exp_t;

  typedef struct {
    int          col;
    int          row;
    logic [29:0] exp;
  } vec_t;

  int n_chk = 0;
  int n_fail = 0;
  exp_t q[$];

  int m_state = 0, mc = 0, mr = 0, m_drop = 0, m_resync = 0;
  bit stall_prev = 0, chk_latency = 0;
  logic [29:0] held_d;
  logic held_sof, held_eol;
  int out_cnt = 0, sof_cnt = 0, eol_cnt = 0, fd_cnt = 0, zero_cnt = 0;
  bit cap_en = 0, want_sof = 0;
  int cap_idx = 0;
  logic [29:0] cap [NPIX];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (reset) begin
      q.delete();
      m_state = 0; mc = 0; mr = 0; m_drop = 0; m_resync = 0;
      stall_prev = 0; chk_latency = 0;
    end else begin
      exp_t e;
      bit acc, last, brd;
      if (chk_latency) chk("latency", {31'd0, y_valid}, 32'd1);
      chk_latency = 0;
      if (stall_prev) begin
        chk("hold_valid", {31'd0, y_valid}, 32'd1);
        chk("hold_data", {2'b0, y_data}, {2'b0, held_d});
        chk("hold_flags", {30'd0, y_sof, y_eol}, {30'd0, held_sof, held_eol});
      end
      if (y_valid && q.size() == 0) chk("spurious_valid", {31'd0, y_valid}, 32'd0);
      if (y_valid && y_ready && q.size() > 0) begin
        e = q.pop_front();
        chk("y_data", {2'b0, y_data}, {2'b0, e.d});
        chk("y_sof", {31'd0, y_sof}, {31'd0, e.sof});
        chk("y_eol", {31'd0, y_eol}, {31'd0, e.eol});
        chk("frame_done", {31'd0, frame_done}, {31'd0, e.last});
        if (want_sof) begin
          chk("sof_after_resync", {31'd0, y_sof}, 32'd1);
          want_sof = 0;
        end
        out_cnt++;
        if (y_sof) sof_cnt++;
        if (y_eol) eol_cnt++;
        if (frame_done) fd_cnt++;
        if (y_data == '0) zero_cnt++;
        if (cap_en) begin
          if (y_sof) cap_idx = 0;
          if (cap_idx < NPIX) cap[cap_idx] = y_data;
          cap_idx++;
        end
      end else begin
        chk("frame_done_idle", {31'd0, frame_done}, 32'd0);
      end
      stall_prev = y_valid && !y_ready;
      held_d = y_data; held_sof = y_sof; held_eol = y_eol;

      acc = x_valid && x_ready;
      if (m_state == 0) begin
        if (acc && m_drop < 65535) m_drop++;
        if (frame_start) begin m_state = 1; mc = 0; mr = 0; end
      end else begin
        last = (mc == WB - 1) && (mr == HB - 1);
        if (acc) begin
          brd = (mc < 2) || (mc >= WB - 2) || (mr < 2) || (mr >= HB - 2);
          e.d = brd ? 30'h0 : x_data;
          e.sof = (mc == 0) && (mr == 0);
          e.eol = (mc == WB - 1);
          e.last = last;
          q.push_back(e);
          chk_latency = 1;
        end
        if (acc && last) begin
          mc = 0; mr = 0;
          m_state = frame_start ? 1 : 0;
        end else if (frame_start) begin
          mc = 0; mr = 0;
          if (m_resync < 255) m_resync++;
        end else if (acc) begin
          if (mc == WB - 1) begin mc = 0; mr++; end
          else mc++;
        end
      end
    end
  end

  task automatic pulse_fs();
    @(posedge clk); #1 frame_start = 1'b1;
    @(posedge clk); #1 frame_start = 1'b0;
  endtask

  // Drives n accepted beats; mode 1 sends data = start + beat index.
  task automatic drive(input int n, input bit mode, input bit rr, input bit rv, input int fs_at);
    int sent = 0;
    int guard = 0;
    while (sent < n && guard < 20000) begin
      @(posedge clk); #1;
      x_valid = rv ? 1'($urandom_range(0, 1)) : 1'b1;
      y_ready = rr ? 1'($urandom_range(0, 1)) : 1'b1;
      frame_start = 1'b0;
      if (sent == fs_at) begin
        x_valid = 1'b1; y_ready = 1'b1; frame_start = 1'b1;
      end
      x_data = mode ? 30'(sent) : CONST_PIX;
      @(negedge clk);
      if (x_valid && x_ready) sent++;
      guard++;
    end
    @(posedge clk); #1;
    x_valid = 1'b0; frame_start = 1'b0; y_ready = 1'b1;
    if (sent < n) chk("drive_timeout", sent, n);
  endtask

  task automatic settle();
    repeat (3) @(posedge clk);
    @(negedge clk);
  endtask

  task automatic clear_counts();
    out_cnt = 0; sof_cnt = 0; eol_cnt = 0; fd_cnt = 0; zero_cnt = 0;
  endtask

  vec_t tbl [11];

  initial begin
    tbl[0]  = '{2, 2, 30'd34};
    tbl[1]  = '{13, 9, 30'd157};
    tbl[2]  = '{1, 2, 30'd0};
    tbl[3]  = '{14, 2, 30'd0};
    tbl[4]  = '{0, 0, 30'd0};
    tbl[5]  = '{2, 1, 30'd0};
    tbl[6]  = '{2, 10, 30'd0};
    tbl[7]  = '{13, 2, 30'd45};
    tbl[8]  = '{5, 5, 30'd85};
    tbl[9]  = '{15, 11, 30'd0};
    tbl[10] = '{2, 9, 30'd146};

    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_y_valid", {31'd0, y_valid}, 32'd0);
    chk("rst_y_data", {2'b0, y_data}, 32'd0);
    chk("rst_flags", {29'd0, y_sof, y_eol, frame_done}, 32'd0);
    chk("rst_resync", {24'd0, resync_count}, 32'd0);
    chk("rst_drop", {16'd0, drop_count}, 32'd0);
    chk("rst_x_ready", {31'd0, x_ready}, 32'd1);
    @(posedge clk); #1 reset = 1'b0;

    // Ten beats before any frame start; the tenth coincides with frame_start.
    clear_counts();
    drive(10, 1'b0, 1'b0, 1'b0, 9);
    settle();
    chk("drop_10", {16'd0, drop_count}, 32'd10);
    chk("drop_model", {16'd0, drop_count}, m_drop);
    chk("no_y_beats", out_cnt, 0);

    // Full frame of constant pixels, no backpressure.
    drive(NPIX, 1'b0, 1'b0, 1'b0, -1);
    settle();
    chk("f1_count", out_cnt, NPIX);
    chk("f1_sof", sof_cnt, 1);
    chk("f1_eol", eol_cnt, HB);
    chk("f1_done", fd_cnt, 1);
    chk("f1_border", zero_cnt, NPIX - (WB - 4) * (HB - 4));
    chk("f1_q_empty", q.size(), 0);

    // Coordinate-coded frame under random backpressure and gaps.
    clear_counts();
    cap_en = 1;
    pulse_fs();
    drive(NPIX, 1'b1, 1'b1, 1'b1, -1);
    settle();
    cap_en = 0;
    chk("f2_count", out_cnt, NPIX);
    chk("f2_done", fd_cnt, 1);
    for (int i = 0; i < 11; i++)
      chk($sformatf("tbl_%0d_%0d", tbl[i].col, tbl[i].row),
          {2'b0, cap[tbl[i].row * WB + tbl[i].col]}, {2'b0, tbl[i].exp});

    // Mid-frame resync with no beat, then a complete frame.
    clear_counts();
    pulse_fs();
    drive(50, 1'b1, 1'b1, 1'b0, -1);
    settle();
    pulse_fs();
    want_sof = 1;
    drive(NPIX, 1'b1, 1'b1, 1'b0, -1);
    settle();
    chk("resync_1", {24'd0, resync_count}, 32'd1);
    chk("resync_done", fd_cnt, 1);
    chk("resync_count_out", out_cnt, 50 + NPIX);

    // Resync coinciding with a beat, then frame_start on the last pixel.
    clear_counts();
    pulse_fs();
    drive(20, 1'b0, 1'b0, 1'b0, 10);
    drive(NPIX - 9, 1'b0, 1'b0, 1'b0, NPIX - 10);
    drive(NPIX, 1'b0, 1'b0, 1'b0, -1);
    settle();
    chk("resync_2", {24'd0, resync_count}, 32'd2);
    chk("resync_model", {24'd0, resync_count}, m_resync);
    chk("last_fs_done", fd_cnt, 2);
    chk("drop_unchanged", {16'd0, drop_count}, 32'd10);

    // Reset while a beat is stalled in the output register.
    pulse_fs();
    @(posedge clk); #1;
    x_valid = 1'b1; y_ready = 1'b0; x_data = 30'h123;
    @(posedge clk); #1 x_valid = 1'b0;
    @(negedge clk);
    chk("stalled_valid", {31'd0, y_valid}, 32'd1);
    #1 reset = 1'b1;
    #1;
    chk("mid_rst_valid", {31'd0, y_valid}, 32'd0);
    chk("mid_rst_data", {2'b0, y_data}, 32'd0);
    chk("mid_rst_counts", {8'd0, resync_count, drop_count}, 32'd0);
    @(posedge clk); @(posedge clk); #1;
    reset = 1'b0; y_ready = 1'b1;
    clear_counts();
    drive(5, 1'b0, 1'b0, 1'b0, -1);
    settle();
    chk("post_rst_drop", {16'd0, drop_count}, 32'd5);
    chk("post_rst_no_out", out_cnt, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end
endmodule
